// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC read-out path that feeds the display.
package rtc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_BURST
    } state_t;

    typedef logic [2:0] reg_idx_t;

    // Burst toward the display: one lead cycle, eight data bytes, then the last byte held.
    localparam int BURST_LEN  = 12;
    localparam int BURST_LEAD = 1;

    // RTC register addresses in the order the display loads them:
    // seconds, minutes, hours, date, month, year, day-of-week, week.
    localparam logic [7:0] RTC_ADDR [0:7] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28
    };

endpackage

// File: rtl/bcd_a_bin.sv
// Packed BCD byte to binary. Nibbles above 9 are passed through the same
// arithmetic unchecked, so 0xFF comes out as 165.
module bcd_a_bin (
    input  logic [7:0] bcd,
    output logic [7:0] bin
);

    // tens * 10 + units, kept in 8 bits
    assign bin = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};

endmodule

// File: rtl/rtc_lectura.sv
// Reads the eight RTC time/date registers over the multiplexed AD bus on each
// update tick, converts them from BCD and replays them to the display as a
// fixed 12-cycle burst. All outputs are registered.
module rtc_lectura #(
    parameter int T_PH  = 4,
    parameter int N_REG = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic       inicioSecuencia,
    output logic [7:0] datoRTC
);

    import rtc_pkg::*;

    localparam logic [3:0] PH_LAST  = 4'(T_PH - 1);
    localparam logic [3:0] BC_LAST  = 4'(BURST_LEN - 1);
    // Burst positions whose next output still indexes a fresh buffer entry.
    localparam logic [3:0] BC_FRESH = 4'(BURST_LEAD + N_REG - 1);
    localparam reg_idx_t   IDX_LAST = reg_idx_t'(N_REG - 1);

    state_t     state;
    logic [3:0] ph;
    logic [3:0] bc;
    reg_idx_t   idx;
    reg_idx_t   idx_next;
    logic       pending;
    logic [7:0] buffer [0:N_REG-1];
    logic [7:0] bcd_bin;

    assign idx_next = idx + 3'd1;

    bcd_a_bin u_bcd_a_bin (
        .bcd (ad_in),
        .bin (bcd_bin)
    );

    // Sequencer: bus phases per register, then the display burst; outputs are
    // loaded on the transition into the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ph              <= '0;
            bc              <= '0;
            idx             <= '0;
            pending         <= 1'b0;
            for (int i = 0; i < N_REG; i++) buffer[i] <= 8'h00;
            cs_n            <= 1'b1;
            rd_n            <= 1'b1;
            wr_n            <= 1'b1;
            a_d             <= 1'b1;
            ad_oe           <= 1'b0;
            ad_out          <= 8'h00;
            busy            <= 1'b0;
            inicioSecuencia <= 1'b0;
            datoRTC         <= 8'h00;
        end else begin
            // Requests arriving while busy collapse into a single extra sequence.
            if (tick && state != S_IDLE) pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick || pending) begin
                        state   <= S_ADDR;
                        idx     <= '0;
                        ph      <= '0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        wr_n    <= 1'b0;
                        a_d     <= 1'b0;
                        ad_oe   <= 1'b1;
                        ad_out  <= RTC_ADDR[0];
                    end
                end

                S_ADDR: begin
                    if (ph == PH_LAST) begin
                        ph     <= '0;
                        state  <= S_GAP1;
                        cs_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        a_d    <= 1'b1;
                        ad_oe  <= 1'b0;
                        ad_out <= 8'h00;
                    end else begin
                        ph <= ph + 4'd1;
                    end
                end

                S_GAP1: begin
                    if (ph == PH_LAST) begin
                        ph    <= '0;
                        state <= S_DATA;
                        cs_n  <= 1'b0;
                        rd_n  <= 1'b0;
                    end else begin
                        ph <= ph + 4'd1;
                    end
                end

                S_DATA: begin
                    if (ph == PH_LAST) begin
                        buffer[idx] <= bcd_bin;
                        ph          <= '0;
                        state       <= S_GAP2;
                        cs_n        <= 1'b1;
                        rd_n        <= 1'b1;
                    end else begin
                        ph <= ph + 4'd1;
                    end
                end

                S_GAP2: begin
                    if (ph == PH_LAST) begin
                        ph <= '0;
                        if (idx == IDX_LAST) begin
                            state           <= S_BURST;
                            bc              <= '0;
                            inicioSecuencia <= 1'b1;
                            datoRTC         <= 8'h00;
                        end else begin
                            idx    <= idx_next;
                            state  <= S_ADDR;
                            cs_n   <= 1'b0;
                            wr_n   <= 1'b0;
                            a_d    <= 1'b0;
                            ad_oe  <= 1'b1;
                            ad_out <= RTC_ADDR[idx_next];
                        end
                    end else begin
                        ph <= ph + 4'd1;
                    end
                end

                S_BURST: begin
                    if (bc == BC_LAST) begin
                        bc              <= '0;
                        inicioSecuencia <= 1'b0;
                        datoRTC         <= 8'h00;
                        if (pending || tick) begin
                            pending <= 1'b0;
                            state   <= S_ADDR;
                            idx     <= '0;
                            ph      <= '0;
                            cs_n    <= 1'b0;
                            wr_n    <= 1'b0;
                            a_d     <= 1'b0;
                            ad_oe   <= 1'b1;
                            ad_out  <= RTC_ADDR[0];
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        bc <= bc + 4'd1;
                        // Position bc+1 shows buffer[bc+1-lead]; past the last entry it holds.
                        if (bc < BC_FRESH) datoRTC <= buffer[bc[2:0]];
                        else               datoRTC <= buffer[IDX_LAST];
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_lectura.sv
// Bench for rtc_lectura: RTC bus model, bus-protocol monitor, table and
// random sequences, and the multi-cycle corner cases (request collapsing,
// request on the last burst cycle, reset in the middle of a read).
module tb_rtc_lectura;

    localparam int T_PH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, inicioSecuencia;
    logic [7:0] datoRTC;

    rtc_lectura #(.T_PH(T_PH)) dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .ad_in           (ad_in),
        .ad_out          (ad_out),
        .ad_oe           (ad_oe),
        .cs_n            (cs_n),
        .rd_n            (rd_n),
        .wr_n            (wr_n),
        .a_d             (a_d),
        .busy            (busy),
        .inicioSecuencia (inicioSecuencia),
        .datoRTC         (datoRTC)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference conversion: decimal weight of the two nibbles.
    function automatic logic [7:0] model_bin(input logic [7:0] b);
        int v;
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        return 8'(v);
    endfunction

    // RTC model: latch the address from the address phase, answer from memory.
    logic [7:0] rtc_mem [0:7];
    logic [7:0] lat_addr = 8'h00;

    always @(negedge clk) begin
        if (cs_n === 1'b0 && a_d === 1'b0 && ad_oe === 1'b1) lat_addr = ad_out;
    end

    always_comb begin
        ad_in = 8'hEE;
        if (lat_addr >= 8'h21 && lat_addr <= 8'h28) ad_in = rtc_mem[lat_addr[2:0] - 3'd1];
    end

    // Monitor: cycle stamps, captured addresses and burst bytes, protocol counters.
    int         cyc = 0;
    logic [7:0] addr_q [$];
    int         addr_cyc_q [$];
    int         rise_cyc_q [$];
    logic [7:0] burst_q [$];
    int         n_bursts = 0, n_cs_fall = 0, n_busy_fall = 0;
    int         n_overlap = 0, n_oe_bad = 0, n_width_bad = 0;
    int         run_cs = 0, run_rd = 0, run_wr = 0;
    bit         chk_width = 1'b1;
    logic       prev_cs_n = 1'b1, prev_inicio = 1'b0, prev_busy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_n === 1'b0 && rd_n === 1'b0) n_overlap++;
        if (ad_oe === 1'b1 && a_d !== 1'b0) n_oe_bad++;
        if (cs_n === 1'b0) run_cs++;
        else begin
            if (run_cs != 0 && chk_width && run_cs != T_PH) n_width_bad++;
            run_cs = 0;
        end
        if (rd_n === 1'b0) run_rd++;
        else begin
            if (run_rd != 0 && chk_width && run_rd != T_PH) n_width_bad++;
            run_rd = 0;
        end
        if (wr_n === 1'b0) run_wr++;
        else begin
            if (run_wr != 0 && chk_width && run_wr != T_PH) n_width_bad++;
            run_wr = 0;
        end
        if (cs_n === 1'b0 && prev_cs_n === 1'b1) begin
            n_cs_fall++;
            if (a_d === 1'b0) begin
                addr_q.push_back(ad_out);
                addr_cyc_q.push_back(cyc);
            end
        end
        if (inicioSecuencia === 1'b1 && prev_inicio === 1'b0) rise_cyc_q.push_back(cyc);
        if (inicioSecuencia === 1'b1) burst_q.push_back(datoRTC);
        if (inicioSecuencia === 1'b0 && prev_inicio === 1'b1) n_bursts++;
        if (busy === 1'b0 && prev_busy === 1'b1) n_busy_fall++;
        prev_cs_n   = cs_n;
        prev_inicio = inicioSecuencia;
        prev_busy   = busy;
    end

    task automatic clear_queues();
        addr_q.delete();
        addr_cyc_q.delete();
        rise_cyc_q.delete();
        burst_q.delete();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_bursts(input int target, input string name);
        int k;
        k = 0;
        while (n_bursts < target && k < 800) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, 32'(n_bursts >= target), 1);
    endtask

    // Waits for the first burst cycle; returns with the bench at that negedge.
    task automatic wait_rise(input string name);
        int k;
        k = 0;
        while (inicioSecuencia !== 1'b1 && k < 800) begin
            @(negedge clk);
            k++;
        end
        check({name, "_rise"}, 32'(inicioSecuencia), 1);
    endtask

    // Compares one 12-byte burst starting at burst_q[base] and its 8 addresses.
    task automatic check_burst(input string name, input int base, input logic [0:7][7:0] exp);
        logic [7:0] want;
        check({name, "_len"}, 32'(burst_q.size() >= base + 12), 1);
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      want = 8'h00;
            else if (k <= 8) want = exp[k-1];
            else             want = exp[7];
            if (base + k < burst_q.size())
                check($sformatf("%s_byte%0d", name, k), burst_q[base+k], want);
        end
    endtask

    task automatic check_addrs(input string name, input int base);
        check({name, "_naddr"}, 32'(addr_q.size() >= base + 8), 1);
        for (int i = 0; i < 8; i++) begin
            if (base + i < addr_q.size())
                check($sformatf("%s_addr%0d", name, i), addr_q[base+i], 8'h21 + 8'(i));
        end
    endtask

    task automatic load_mem(input logic [0:7][7:0] v);
        for (int i = 0; i < 8; i++) rtc_mem[i] = v[i];
    endtask

    task automatic run_seq(input string name, input logic [0:7][7:0] bcd, input logic [0:7][7:0] exp);
        int b0;
        load_mem(bcd);
        clear_queues();
        b0 = n_bursts;
        pulse_tick();
        wait_bursts(b0 + 1, name);
        check_addrs(name, 0);
        check_burst(name, 0, exp);
        repeat (5) @(negedge clk);
    endtask

    typedef struct packed {
        logic [0:7][7:0] bcd;
        logic [0:7][7:0] exp;
    } vec_t;

    vec_t tbl [0:2];

    initial begin
        int tick_cyc, b0, cs0, bf0, bad;
        logic [0:7][7:0] rb, re;

        tbl[0].bcd = {8'h24, 8'h04, 8'h03, 8'h23, 8'h12, 8'h17, 8'h05, 8'h04};
        tbl[0].exp = {8'd24, 8'd4,  8'd3,  8'd23, 8'd12, 8'd17, 8'd5,  8'd4};
        tbl[1].bcd = {8'h59, 8'h00, 8'h99, 8'h31, 8'h00, 8'h01, 8'h09, 8'h10};
        tbl[1].exp = {8'd59, 8'd0,  8'd99, 8'd31, 8'd0,  8'd1,  8'd9,  8'd10};
        tbl[2].bcd = {8'hFF, 8'hA0, 8'h0A, 8'h45, 8'h88, 8'h90, 8'h19, 8'h50};
        tbl[2].exp = {8'd165, 8'd100, 8'd10, 8'd45, 8'd88, 8'd90, 8'd19, 8'd50};

        reset = 1'b1;
        tick  = 1'b0;
        load_mem(tbl[0].bcd);

        // Reset held three cycles, then quiet with no request.
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_rd_n", 32'(rd_n), 1);
        check("rst_wr_n", 32'(wr_n), 1);
        check("rst_a_d", 32'(a_d), 1);
        check("rst_ad_oe", 32'(ad_oe), 0);
        check("rst_ad_out", 32'(ad_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_inicio", 32'(inicioSecuencia), 0);
        check("rst_dato", 32'(datoRTC), 0);
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({cs_n, rd_n, wr_n, a_d, ad_oe, busy, inicioSecuencia} !== 7'b1111000 ||
                ad_out !== 8'h00 || datoRTC !== 8'h00) bad++;
        end
        check("idle_quiet", 32'(bad), 0);
        check("idle_no_cs", 32'(n_cs_fall), 0);

        // Single request: latency, address cadence, burst position and content.
        clear_queues();
        tick_cyc = cyc;
        b0 = n_bursts;
        pulse_tick();
        wait_bursts(b0 + 1, "single");
        check("single_first_addr_lat", 32'(addr_cyc_q.size() > 0 ? addr_cyc_q[0] - tick_cyc : -1), 1);
        for (int i = 1; i < 8; i++)
            if (i < addr_cyc_q.size())
                check($sformatf("single_period%0d", i), 32'(addr_cyc_q[i] - addr_cyc_q[i-1]), 16);
        check("single_rise_lat",
              32'((rise_cyc_q.size() > 0 && addr_cyc_q.size() > 0) ? rise_cyc_q[0] - addr_cyc_q[0] : -1), 128);
        check_addrs("single", 0);
        check_burst("single", 0, tbl[0].exp);
        repeat (5) @(negedge clk);
        check("single_idle_busy", 32'(busy), 0);

        // Table vectors.
        for (int t = 0; t < 3; t++) run_seq($sformatf("tbl%0d", t), tbl[t].bcd, tbl[t].exp);

        // Random contents checked against the reference conversion.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                rb[i] = 8'($urandom_range(0, 255));
                re[i] = model_bin(rb[i]);
            end
            run_seq($sformatf("rnd%0d", r), rb, re);
        end

        // Several requests during the read plus one on the last burst cycle:
        // exactly one back-to-back extra sequence.
        load_mem(tbl[1].bcd);
        clear_queues();
        b0  = n_bursts;
        bf0 = n_busy_fall;
        pulse_tick();
        repeat (20) @(negedge clk);
        pulse_tick();
        repeat (30) @(negedge clk);
        pulse_tick();
        repeat (40) @(negedge clk);
        pulse_tick();
        wait_rise("collapse");
        repeat (11) @(negedge clk);
        pulse_tick();
        wait_bursts(b0 + 2, "collapse");
        repeat (200) @(negedge clk);
        check("collapse_nbursts", 32'(n_bursts - b0), 2);
        check("collapse_busy_falls", 32'(n_busy_fall - bf0), 1);
        check("collapse_b2b",
              32'((addr_cyc_q.size() > 8 && rise_cyc_q.size() > 0) ? addr_cyc_q[8] - rise_cyc_q[0] : -1), 12);
        check_addrs("collapse_s1", 0);
        check_addrs("collapse_s2", 8);
        check_burst("collapse_s1", 0, tbl[1].exp);
        check_burst("collapse_s2", 12, tbl[1].exp);

        // Only a request on the last burst cycle.
        load_mem(tbl[2].bcd);
        clear_queues();
        b0 = n_bursts;
        pulse_tick();
        wait_rise("lastcyc");
        repeat (11) @(negedge clk);
        pulse_tick();
        wait_bursts(b0 + 2, "lastcyc");
        repeat (200) @(negedge clk);
        check("lastcyc_nbursts", 32'(n_bursts - b0), 2);
        check("lastcyc_b2b",
              32'((addr_cyc_q.size() > 8 && rise_cyc_q.size() > 0) ? addr_cyc_q[8] - rise_cyc_q[0] : -1), 12);
        check_burst("lastcyc_s2", 12, tbl[2].exp);

        // Reset in the data phase of register 3 with a request already pending.
        load_mem(tbl[0].bcd);
        clear_queues();
        b0 = n_bursts;
        pulse_tick();
        repeat (10) @(negedge clk);
        pulse_tick();
        bad = 0;
        while (!(addr_q.size() >= 4 && rd_n === 1'b0) && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        check("rstmid_reach_data3", 32'(addr_q.size() == 4 && rd_n === 1'b0), 1);
        chk_width = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_cs_n", 32'(cs_n), 1);
        check("rstmid_rd_n", 32'(rd_n), 1);
        check("rstmid_ad_oe", 32'(ad_oe), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_inicio", 32'(inicioSecuencia), 0);
        cs0 = n_cs_fall;
        repeat (300) @(negedge clk);
        chk_width = 1'b1;
        check("rstmid_no_activity", 32'(n_cs_fall - cs0), 0);
        check("rstmid_no_burst", 32'(n_bursts - b0), 0);
        run_seq("rstmid_after", tbl[1].bcd, tbl[1].exp);

        // Bus protocol over the whole run.
        check("bus_rd_wr_overlap", 32'(n_overlap), 0);
        check("bus_oe_in_data", 32'(n_oe_bad), 0);
        check("bus_strobe_width", 32'(n_width_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
